// File: rtl/data_memory_line.sv
// rtl/data_memory_line.sv - 256-bit line memory answering each request after a fixed LATENCY
// Optional feature macro MEM_RANGE_CHECK_EN: requests with addr_i[31:14] != 0 leave the array untouched and read zeros.
module data_memory_line #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] LOAD_COUNT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [7:0]     count;
    logic [7:0]     count_next;
    logic           accept;
    logic           finish;

    logic [IW-1:0]  index_in;
    logic           oob_in;
    logic [IW-1:0]  index_q;
    logic           oob_q;
    logic [255:0]   wdata_q;
    logic           write_q;
    logic [255:0]   rdata_q;
    logic           unused_addr;

    logic [255:0]   mem [DEPTH];

    assign index_in = IW'(32'(addr_i[13:5]) % DEPTH);

`ifdef MEM_RANGE_CHECK_EN
    assign oob_in = |addr_i[31:14];
`else
    assign oob_in = 1'b0;
`endif
    assign unused_addr = ^{addr_i[31:14], addr_i[4:0]};

    // finish marks the WAIT->ACK edge: the single point where the array and data_o change
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    accept     = 1'b1;
                    count_next = LOAD_COUNT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                count_next = count - 8'd1;
                if (count == 8'd1) begin
                    finish     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            count   <= 8'd0;
            index_q <= '0;
            oob_q   <= 1'b0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                index_q <= index_in;
                oob_q   <= oob_in;
                wdata_q <= data_i;
                write_q <= write_i;
            end
            if (finish && !write_q) begin
                rdata_q <= oob_q ? '0 : mem[index_q];
            end
        end
    end

    // The array has no reset so preloaded contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (finish && write_q && !oob_q) begin
            mem[index_q] <= wdata_q;
        end
    end

    assign ack_o  = (state == ACK);
    assign busy_o = (state != IDLE);
    assign data_o = rdata_q;

endmodule

// File: doc/data_memory_line.md
DATA_MEMORY_LINE -- requirements
Module: data_memory_line

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning the number of 256-bit lines stored.
REQ-002 SHALL have parameter LATENCY, default 10, meaning the number of cycles from request acceptance to ack (legal range 2..255).
REQ-003 SHALL have port clk_i  input  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port addr_i  input  32  byte address from the dcache controller; the line index is addr_i[13:5].
REQ-006 SHALL have port data_i  input  256  write line data.
REQ-007 SHALL have port enable_i  input  1  request valid.
REQ-008 SHALL have port write_i  input  1  request is a write (1) or a read (0).
REQ-009 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port data_o  output  256  read line data, valid while ack_o=1.
REQ-011 SHALL have port busy_o  output  1  request in progress; high while not IDLE.

Function
REQ-012 SHALL implement states IDLE, WAIT and ACK.
REQ-013 In IDLE with enable_i=1 at an edge, SHALL latch addr_i, data_i and write_i, load the counter with LATENCY-1, and go to WAIT.
REQ-014 In WAIT, SHALL decrement the counter every edge, and SHALL go to ACK at the edge where the counter equals 1.
- Result: ack_o is high exactly LATENCY cycles after the accepting edge.
REQ-015 In ACK, SHALL drive ack_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-016 SHALL sample enable_i only in IDLE.
- addr_i, data_i, write_i and enable_i are ignored in WAIT and ACK, including enable_i held high during the ack cycle.
- A new request is accepted no earlier than the first IDLE cycle after ACK.
REQ-017 SHALL commit a write to the latched line on the edge that enters ACK; the array is unchanged before that edge.
REQ-018 SHALL load data_o from the latched line on the edge that enters ACK.
- data_o holds that value until the next read completes.
- A write leaves data_o unchanged.
REQ-019 A read of a line written by the immediately preceding request SHALL return the new data.
REQ-020 Line index arithmetic SHALL use addr_i[13:5] with no carry.
- addr_i[4:0] is ignored.
REQ-021 SHALL produce no combinational path from any input to ack_o, data_o or busy_o.

Reset
REQ-022 While rst_i=0, SHALL force IDLE, counter=0, ack_o=0, busy_o=0 and data_o=0 immediately, independent of clk_i.
REQ-023 Reset during WAIT or ACK SHALL abort the request; a pending write is not committed.
REQ-024 Reset SHALL NOT clear the memory array; contents preloaded by the bench survive reset.

Configuration
REQ-025 With macro MEM_RANGE_CHECK_EN defined, a request with addr_i[31:14] nonzero SHALL still complete with normal timing and ack, but:
- a write leaves the array unchanged;
- a read returns all zeros.
REQ-026 Without MEM_RANGE_CHECK_EN, addr_i[31:14] SHALL be ignored and the index wraps modulo DEPTH.

Verification
REQ-027 Read: preload line 3 = 256'hA5..A5; enable_i=1, write_i=0, addr_i=32'h60 at edge T -> ack_o=1 only in cycle T+10; data_o=A5..A5; busy_o high in T+1..T+10.
REQ-028 Write then read: write 256'h1234 to addr 32'h80, then read addr 32'h80 in the first IDLE cycle -> data_o=256'h1234 at the second ack; the first ack leaves data_o unchanged.
REQ-029 Held enable: keep enable_i=1 through a read ack -> exactly one ack per 11 cycles (10 WAIT/ACK cycles + 1 IDLE); no duplicate ack.
REQ-030 Ignored inputs: change addr_i to 32'h20 and write_i to 1 during WAIT -> the original read address is serviced; line 1 is unmodified.
REQ-031 Reset mid-write: write 256'hFF to addr 32'h40, pull rst_i low in cycle T+5 -> ack_o, busy_o and data_o drop to 0 at once; line 2 keeps its old value; the next request is timed normally.
REQ-032 Range check: with MEM_RANGE_CHECK_EN, write to 32'h4000 then read 32'h0 -> line 0 unchanged; a read of 32'h4000 returns 0. Without the macro, line 0 = written data.
